// File: rtl/rv32i_dmem_responder.sv
// rv32i_dmem_responder: data-port responder for an RV32I core.
// Local-window accesses hit an internal byte-enabled SRAM; everything else
// goes out over an Avalon-MM master with waitrequest and a timeout abort.
module rv32i_dmem_responder #(
  parameter int unsigned ADDR_BITS  = 12,
  parameter logic [31:0] LOCAL_BASE = 32'h0000_0000,
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        store,
  input  logic [31:0] addr,
  input  logic [3:0]  st_be,
  input  logic [31:0] wr_data,
  output logic [31:0] ld_data,
  output logic        stall,
  output logic        bus_err,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [3:0]  avm_byteenable,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LRESP = 2'd1,
    EXT   = 2'd2,
    XRESP = 2'd3
  } state_t;

  localparam int unsigned TAG_LSB   = ADDR_BITS + 2;
  localparam logic [7:0]  TIMEOUT_C = 8'(TIMEOUT);

  state_t                 state_r;
  state_t                 state_next_s;
  logic                   local_s;
  logic [ADDR_BITS-1:0]   word_idx_s;
  logic                   lcl_rd_s;
  logic                   lcl_wr_s;
  logic                   ext_req_s;
  logic                   ext_done_s;
  logic                   ext_tout_s;
  logic                   stall_s;
  logic [7:0]             tout_cnt_r;
  logic                   ext_is_rd_r;
  logic [31:0]            ld_data_r;
  logic                   bus_err_r;
  logic [31:0]            avm_address_r;
  logic                   avm_read_r;
  logic                   avm_write_r;
  logic [3:0]             avm_byteenable_r;
  logic [31:0]            avm_writedata_r;
  logic [31:0]            mem_r [0:(1 << ADDR_BITS) - 1];
  logic                   unused_addr_lsb_s;

  // Word-aligned addresses: the two byte-offset bits carry no information.
  assign unused_addr_lsb_s = ^addr[1:0];

  assign local_s    = (addr[31:TAG_LSB] == LOCAL_BASE[31:TAG_LSB]);
  assign word_idx_s = addr[TAG_LSB-1:2];

  // Next-state, access-decode and combinational stall generation.
  always_comb begin
    state_next_s = state_r;
    lcl_rd_s     = 1'b0;
    lcl_wr_s     = 1'b0;
    ext_req_s    = 1'b0;
    ext_done_s   = 1'b0;
    ext_tout_s   = 1'b0;
    stall_s      = 1'b0;
    case (state_r)
      IDLE: begin
        // load wins over a simultaneous store; the store is simply dropped
        if (load && local_s) begin
          lcl_rd_s     = 1'b1;
          stall_s      = 1'b1;
          state_next_s = LRESP;
        end else if (store && local_s) begin
          lcl_wr_s     = 1'b1;
        end else if (load || store) begin
          ext_req_s    = 1'b1;
          stall_s      = 1'b1;
          state_next_s = EXT;
        end else begin
          state_next_s = IDLE;
        end
      end
      LRESP: begin
        state_next_s = IDLE;
      end
      EXT: begin
        stall_s = 1'b1;
        if (!avm_waitrequest) begin
          ext_done_s   = 1'b1;
          state_next_s = XRESP;
        end else if (tout_cnt_r == TIMEOUT_C) begin
          ext_tout_s   = 1'b1;
          state_next_s = XRESP;
        end else begin
          state_next_s = EXT;
        end
      end
      XRESP: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Local SRAM byte-lane writes (contents deliberately not reset).
  always_ff @(posedge clk) begin
    if (lcl_wr_s) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) begin
          mem_r[word_idx_s][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Load-data register: SRAM word, external read data, or the abort pattern.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ld_data_r <= 32'h0000_0000;
    end else if (lcl_rd_s) begin
      ld_data_r <= mem_r[word_idx_s];
    end else if (ext_done_s && ext_is_rd_r) begin
      ld_data_r <= avm_readdata;
    end else if (ext_tout_s && ext_is_rd_r) begin
      ld_data_r <= ERR_DATA;
    end
  end

  // Avalon master request registers, wait counter and timeout pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_address_r    <= 32'h0000_0000;
      avm_read_r       <= 1'b0;
      avm_write_r      <= 1'b0;
      avm_byteenable_r <= 4'b0000;
      avm_writedata_r  <= 32'h0000_0000;
      ext_is_rd_r      <= 1'b0;
      tout_cnt_r       <= 8'd0;
      bus_err_r        <= 1'b0;
    end else begin
      bus_err_r <= ext_tout_s;
      if (ext_req_s) begin
        avm_address_r    <= addr;
        avm_read_r       <= load;
        avm_write_r      <= ~load;
        avm_byteenable_r <= load ? 4'b1111 : st_be;
        avm_writedata_r  <= wr_data;
        ext_is_rd_r      <= load;
        tout_cnt_r       <= 8'd0;
      end else if (ext_done_s || ext_tout_s) begin
        avm_read_r  <= 1'b0;
        avm_write_r <= 1'b0;
      end else if ((state_r == EXT) && (tout_cnt_r != 8'hFF)) begin
        // saturating: the counter never wraps back to zero
        tout_cnt_r <= tout_cnt_r + 8'd1;
      end
    end
  end

  assign ld_data        = ld_data_r;
  assign stall          = stall_s;
  assign bus_err        = bus_err_r;
  assign avm_address    = avm_address_r;
  assign avm_read       = avm_read_r;
  assign avm_write      = avm_write_r;
  assign avm_byteenable = avm_byteenable_r;
  assign avm_writedata  = avm_writedata_r;

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Self-checking bench for rv32i_dmem_responder: directed cases plus random
// traffic, expected responses queued by the driver and checked by a monitor.
module tb_rv32i_dmem_responder;

  localparam int unsigned TB_TIMEOUT = 5;
  localparam logic [31:0] TB_ERR     = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load = 1'b0;
  logic        store = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [3:0]  st_be = 4'h0;
  logic [31:0] wr_data = 32'h0;
  logic [31:0] ld_data;
  logic        stall;
  logic        bus_err;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'h0;
  logic        avm_waitrequest = 1'b1;

  rv32i_dmem_responder #(
    .ADDR_BITS(12), .LOCAL_BASE(32'h0000_0000),
    .TIMEOUT(TB_TIMEOUT), .ERR_DATA(TB_ERR)
  ) dut (
    .clk(clk), .reset_n(reset_n), .load(load), .store(store), .addr(addr),
    .st_be(st_be), .wr_data(wr_data), .ld_data(ld_data), .stall(stall),
    .bus_err(bus_err), .avm_address(avm_address), .avm_read(avm_read),
    .avm_write(avm_write), .avm_byteenable(avm_byteenable),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_load;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_mem [16];

  // slave configuration, written by the driver only
  int unsigned wait_cfg  = 0;
  logic [31:0] ext_rdata = 32'h0;
  int unsigned wcnt      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Avalon slave: holds waitrequest for wait_cfg strobe cycles, then answers.
  always @(negedge clk) begin
    if (avm_read || avm_write) begin
      if (wcnt < wait_cfg) begin
        avm_waitrequest = 1'b1;
        wcnt++;
      end else begin
        avm_waitrequest = 1'b0;
      end
      avm_readdata = ext_rdata;
    end else begin
      wcnt = 0;
      avm_waitrequest = 1'b1;
      avm_readdata = 32'h0;
    end
  end

  // Monitor: every completed request (request held, stall low) pops one entry.
  always @(negedge clk) begin
    if (reset_n && (load || store) && !stall) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: completion with empty queue at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_bus_err", {31'b0, bus_err}, {31'b0, e.err});
        if (e.is_load) check("sb_ld_data", ld_data, e.data);
      end
    end
  end

  // Issue one request, queue its expected result, check bus-side behaviour.
  task automatic do_req(input logic ld, input logic st, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd,
                        input int unsigned wt, input logic [31:0] rd);
    exp_t        e;
    logic        lcl;
    logic        tout;
    int unsigned exp_strobes;
    int unsigned exp_cycles;
    int unsigned cycles;
    int unsigned strobes;
    logic        done;
    lcl  = (a[31:14] == 18'h0);
    tout = (wt > TB_TIMEOUT);
    e.is_load = ld;
    e.data    = 32'h0;
    e.err     = 1'b0;
    exp_strobes = 0;
    if (lcl) begin
      if (ld) begin
        e.data = model_mem[a[5:2]];
        exp_cycles = 2;
      end else begin
        for (int b = 0; b < 4; b++)
          if (be[b]) model_mem[a[5:2]][8*b +: 8] = wd[8*b +: 8];
        exp_cycles = 1;
      end
    end else begin
      e.data = tout ? TB_ERR : rd;
      e.err  = tout;
      exp_strobes = tout ? TB_TIMEOUT + 1 : wt + 1;
      exp_cycles  = exp_strobes + 2;
    end
    exp_q.push_back(e);
    wait_cfg  = wt;
    ext_rdata = rd;
    load = ld; store = st; addr = a; st_be = be; wr_data = wd;
    cycles = 0; strobes = 0; done = 1'b0;
    while (!done && cycles < 300) begin
      @(negedge clk);
      cycles++;
      if (avm_read || avm_write) begin
        strobes++;
        if (strobes == 1) begin
          check("avm_address", avm_address, a);
          check("avm_read", {31'b0, avm_read}, {31'b0, ld});
          check("avm_write", {31'b0, avm_write}, {31'b0, ~ld});
          check("avm_byteenable", {28'b0, avm_byteenable}, {28'b0, (ld ? 4'hF : be)});
          if (!ld) check("avm_writedata", avm_writedata, wd);
        end
      end
      if (!stall) done = 1'b1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_timeout: stall never released for addr %h", a);
    end
    check("strobe_cycles", 32'(strobes), 32'(exp_strobes));
    check("req_cycles", 32'(cycles), 32'(exp_cycles));
    @(posedge clk);
    #1;
    load = 1'b0; store = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int unsigned kind;

    // Reset values while held in reset
    repeat (3) @(negedge clk);
    check("rst_ld_data", ld_data, 32'h0);
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_bus_err", {31'b0, bus_err}, 32'h0);
    check("rst_avm_rw", {30'b0, avm_read, avm_write}, 32'h0);
    check("rst_avm_address", avm_address, 32'h0);
    check("rst_avm_be", {28'b0, avm_byteenable}, 32'h0);
    check("rst_avm_wdata", avm_writedata, 32'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back full-word local stores initialise the model window
    for (int i = 0; i < 16; i++)
      do_req(1'b0, 1'b1, 32'(i * 4), 4'hF, $urandom, 0, 32'h0);

    // Partial store then load at 0x10
    do_req(1'b0, 1'b1, 32'h10, 4'b0011, 32'h0000_BEEF, 0, 32'h0);
    do_req(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 0, 32'h0);
    // Readback of first three words after back-to-back stores
    for (int i = 0; i < 3; i++)
      do_req(1'b1, 1'b0, 32'(i * 4), 4'h0, 32'h0, 0, 32'h0);

    // External load with three wait cycles
    do_req(1'b1, 1'b0, 32'h8000_0000, 4'h0, 32'h0, 3, 32'h1234_5678);
    // External store with waitrequest stuck: timeout abort
    do_req(1'b0, 1'b1, 32'h8000_0004, 4'b1000, 32'hA500_0000, 1000, 32'h0);
    // Timeout boundary: wait == TIMEOUT completes, wait == TIMEOUT+1 aborts
    do_req(1'b1, 1'b0, 32'h8000_0008, 4'h0, 32'h0, TB_TIMEOUT, 32'hCAFE_F00D);
    do_req(1'b1, 1'b0, 32'h8000_000C, 4'h0, 32'h0, TB_TIMEOUT + 1, 32'h1111_2222);

    // load & store together on a local word: load served, SRAM unchanged
    do_req(1'b1, 1'b1, 32'h20, 4'hF, 32'h5555_AAAA, 0, 32'h0);
    do_req(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 0, 32'h0);

    // Reset asserted mid external read
    wait_cfg = 1000;
    load = 1'b1; addr = 32'h8000_0010;
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    load = 1'b0;
    #1;
    check("rst_mid_ext_avm_read", {31'b0, avm_read}, 32'h0);
    check("rst_mid_ext_bus_err", {31'b0, bus_err}, 32'h0);
    check("rst_mid_ext_ld_data", ld_data, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    // After release the block is idle and the SRAM kept its contents
    do_req(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 0, 32'h0);

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 5);
      d    = $urandom;
      case (kind)
        0: do_req(1'b0, 1'b1, 32'($urandom_range(0, 15)) << 2, 4'($urandom), d, 0, 32'h0);
        1: do_req(1'b1, 1'b0, 32'($urandom_range(0, 15)) << 2, 4'h0, 32'h0, 0, 32'h0);
        2: do_req(1'b1, 1'b1, 32'($urandom_range(0, 15)) << 2, 4'($urandom), d, 0, 32'h0);
        3: begin
          a = 32'h8000_0000 + (32'($urandom_range(0, 255)) << 2);
          do_req(1'b1, 1'b0, a, 4'h0, 32'h0, $urandom_range(0, 7), d);
        end
        4: begin
          a = 32'h8000_0000 + (32'($urandom_range(0, 255)) << 2);
          do_req(1'b0, 1'b1, a, 4'($urandom), d, $urandom_range(0, 7), 32'h0);
        end
        default: begin
          a = 32'h8000_0000 + (32'($urandom_range(0, 255)) << 2);
          do_req(1'b1, 1'b1, a, 4'($urandom), d, $urandom_range(0, 7), $urandom);
        end
      endcase
    end

    repeat (2) @(negedge clk);
    check("sb_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
